// File: rtl/spi_slave_cmd_ctrl_pkg.sv
// Shared opcodes, FSM state encoding and status bit positions for the SPI slave command sequencer.
package spi_slave_pkg;

   localparam logic [7:0] OP_WRITE_MEM  = 8'h02;
   localparam logic [7:0] OP_READ_MEM   = 8'h0B;
   localparam logic [7:0] OP_SET_WRAP   = 8'h11;
   localparam logic [7:0] OP_CLR_STATUS = 8'h07;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_WRDATA,
      ST_RDWAIT,
      ST_WRAP,
      ST_IGNORE
   } state_t;

   // Bit positions inside status = {addr_err, bad_cmd, overflow}
   localparam int STAT_OVERFLOW = 0;
   localparam int STAT_BAD_CMD  = 1;
   localparam int STAT_ADDR_ERR = 2;

endpackage

// File: rtl/spi_slave_cmd_ctrl_if.sv
// Front-end and SPI-to-AXI plug signals of the command sequencer; slave = sequencer side.
interface spi_slave_cmd_ctrl_if #(
   parameter int AXI_ADDR_WIDTH = 32
);
   logic                      cs;
   logic [7:0]                cmd;
   logic                      cmd_valid;
   logic [31:0]               word;
   logic                      word_valid;
   logic [AXI_ADDR_WIDTH-1:0] rxtx_addr;
   logic                      rxtx_addr_valid;
   logic                      start_tx;
   logic [31:0]               rx_data;
   logic                      rx_valid;
   logic                      rx_ready;
   logic [15:0]               wrap_length;

   modport slave (
      input  cs, cmd, cmd_valid, word, word_valid, rx_ready,
      output rxtx_addr, rxtx_addr_valid, start_tx, rx_data, rx_valid, wrap_length
   );

   modport master (
      output cs, cmd, cmd_valid, word, word_valid, rx_ready,
      input  rxtx_addr, rxtx_addr_valid, start_tx, rx_data, rx_valid, wrap_length
   );
endinterface

// File: rtl/spi_slave_cmd_ctrl.sv
// SPI frame command sequencer: opcode/address decode, plug pulses, 1-entry write buffer, wrap/status regs.
// Optional address window filter enabled by defining SPI_SLAVE_CMD_ADDR_FILTER_EN.
module spi_slave_cmd_ctrl
   import spi_slave_pkg::*;
#(
   parameter int          AXI_ADDR_WIDTH = 32,
   parameter logic [15:0] WRAP_RESET     = 16'h0000,
   parameter logic [31:0] ADDR_BASE      = 32'h1C00_0000,
   parameter logic [31:0] ADDR_SIZE      = 32'h0008_0000
) (
   input  logic                 axi_aclk,
   input  logic                 axi_aresetn,
   spi_slave_cmd_ctrl_if.slave  bus,
   output logic [2:0]           status
);

`ifdef SPI_SLAVE_CMD_ADDR_FILTER_EN
   localparam bit FILTER_EN = 1'b1;
`else
   localparam bit FILTER_EN = 1'b0;
`endif

   // One extra bit so ADDR_BASE + ADDR_SIZE cannot wrap around
   localparam int                CW     = AXI_ADDR_WIDTH + 1;
   localparam logic [CW-1:0]     WIN_LO = CW'(ADDR_BASE);
   localparam logic [CW-1:0]     WIN_HI = CW'(ADDR_BASE) + CW'(ADDR_SIZE);

   state_t                    state_reg;
   logic                      is_read_reg;
   logic [AXI_ADDR_WIDTH-1:0] rxtx_addr_reg;
   logic                      addr_valid_reg;
   logic                      start_tx_reg;
   logic [31:0]               rx_data_reg;
   logic                      rx_valid_reg;
   logic [15:0]               wrap_reg;
   logic [2:0]                status_reg;

   logic [AXI_ADDR_WIDTH-1:0] addr_word;
   logic [CW-1:0]             addr_ext;
   logic                      addr_ok;

   assign addr_word = AXI_ADDR_WIDTH'(bus.word);
   assign addr_ext  = {1'b0, addr_word};
   assign addr_ok   = !FILTER_EN || ((addr_ext >= WIN_LO) && (addr_ext < WIN_HI));

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         state_reg      <= ST_IDLE;
         is_read_reg    <= 1'b0;
         rxtx_addr_reg  <= '0;
         addr_valid_reg <= 1'b0;
         start_tx_reg   <= 1'b0;
         rx_data_reg    <= '0;
         rx_valid_reg   <= 1'b0;
         wrap_reg       <= WRAP_RESET;
         status_reg     <= '0;
      end else begin
         addr_valid_reg <= 1'b0;
         start_tx_reg   <= 1'b0;
         // Drain is independent of the frame so a pending entry survives cs rising
         if (rx_valid_reg && bus.rx_ready)
            rx_valid_reg <= 1'b0;

         if (bus.cs) begin
            state_reg <= ST_IDLE;
         end else begin
            case (state_reg)
               ST_IDLE: state_reg <= ST_CMD;
               ST_CMD: begin
                  if (bus.cmd_valid) begin
                     case (bus.cmd)
                        OP_WRITE_MEM, OP_READ_MEM: begin
                           is_read_reg <= (bus.cmd == OP_READ_MEM);
                           state_reg   <= ST_ADDR;
                        end
                        OP_SET_WRAP: state_reg <= ST_WRAP;
                        OP_CLR_STATUS: begin
                           status_reg <= '0;
                           state_reg  <= ST_IGNORE;
                        end
                        default: begin
                           status_reg[STAT_BAD_CMD] <= 1'b1;
                           state_reg                <= ST_IGNORE;
                        end
                     endcase
                  end
               end
               ST_ADDR: begin
                  if (bus.word_valid) begin
                     if (addr_ok) begin
                        rxtx_addr_reg  <= addr_word;
                        addr_valid_reg <= 1'b1;
                        start_tx_reg   <= is_read_reg;
                        state_reg      <= is_read_reg ? ST_RDWAIT : ST_WRDATA;
                     end else begin
                        status_reg[STAT_ADDR_ERR] <= 1'b1;
                        state_reg                 <= ST_IGNORE;
                     end
                  end
               end
               ST_WRDATA: begin
                  // Later assignment overrides the pop above: push+pop keeps rx_valid high
                  if (bus.word_valid) begin
                     if (!rx_valid_reg || bus.rx_ready) begin
                        rx_data_reg  <= bus.word;
                        rx_valid_reg <= 1'b1;
                     end else begin
                        status_reg[STAT_OVERFLOW] <= 1'b1;
                     end
                  end
               end
               ST_WRAP: begin
                  if (bus.word_valid) begin
                     wrap_reg  <= bus.word[15:0];
                     state_reg <= ST_IGNORE;
                  end
               end
               ST_RDWAIT, ST_IGNORE: state_reg <= state_reg;
               default: state_reg <= ST_IDLE;
            endcase
         end
      end
   end

   assign bus.rxtx_addr       = rxtx_addr_reg;
   assign bus.rxtx_addr_valid = addr_valid_reg;
   assign bus.start_tx        = start_tx_reg;
   assign bus.rx_data         = rx_data_reg;
   assign bus.rx_valid        = rx_valid_reg;
   assign bus.wrap_length     = wrap_reg;
   assign status = {FILTER_EN & status_reg[STAT_ADDR_ERR], status_reg[STAT_BAD_CMD],
                    status_reg[STAT_OVERFLOW]};

endmodule

// File: tb/tb_spi_slave_cmd_ctrl.sv
// Directed bench for spi_slave_cmd_ctrl; address-filter expectations follow SPI_SLAVE_CMD_ADDR_FILTER_EN.
module tb_spi_slave_cmd_ctrl;

`ifdef SPI_SLAVE_CMD_ADDR_FILTER_EN
   localparam bit FILT = 1'b1;
`else
   localparam bit FILT = 1'b0;
`endif

   logic       axi_aclk = 1'b0;
   logic       axi_aresetn;
   logic [2:0] status;
   int         err_cnt = 0;
   int         chk_cnt = 0;

   spi_slave_cmd_ctrl_if #(.AXI_ADDR_WIDTH(32)) bus ();

   spi_slave_cmd_ctrl #(
      .AXI_ADDR_WIDTH(32),
      .WRAP_RESET    (16'h0000),
      .ADDR_BASE     (32'h1C00_0000),
      .ADDR_SIZE     (32'h0008_0000)
   ) dut (
      .axi_aclk   (axi_aclk),
      .axi_aresetn(axi_aresetn),
      .bus        (bus),
      .status     (status)
   );

   always #5 axi_aclk = ~axi_aclk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge axi_aclk);
      #1;
   endtask

   task automatic send_cmd(input logic [7:0] op);
      bus.cmd       = op;
      bus.cmd_valid = 1'b1;
      tick();
      bus.cmd_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      bus.word       = w;
      bus.word_valid = 1'b1;
      tick();
      bus.word_valid = 1'b0;
   endtask

   task automatic start_frame();
      bus.cs = 1'b0;
      tick();
   endtask

   task automatic end_frame();
      bus.cs = 1'b1;
      tick();
      tick();
   endtask

   initial begin
      int n;
      bus.cs         = 1'b1;
      bus.cmd        = 8'h00;
      bus.cmd_valid  = 1'b0;
      bus.word       = 32'h0;
      bus.word_valid = 1'b0;
      bus.rx_ready   = 1'b0;
      axi_aresetn    = 1'b0;
      repeat (3) @(posedge axi_aclk);
      #1;
      check("rst_wrap",       32'(bus.wrap_length),     32'h0000);
      check("rst_status",     32'(status),              32'h0);
      check("rst_addr_valid", 32'(bus.rxtx_addr_valid), 32'h0);
      check("rst_start_tx",   32'(bus.start_tx),        32'h0);
      check("rst_rx_valid",   32'(bus.rx_valid),        32'h0);
      check("rst_addr",       bus.rxtx_addr,            32'h0);
      axi_aresetn = 1'b1;
      tick();

      // READ_MEM: pulses exactly one cycle after the address word
      start_frame();
      send_cmd(8'h0B);
      send_word(32'h1C00_0100);
      check("rd_addr",       bus.rxtx_addr,            32'h1C00_0100);
      check("rd_addr_valid", 32'(bus.rxtx_addr_valid), 32'h1);
      check("rd_start",      32'(bus.start_tx),        32'h1);
      tick();
      check("rd_addr_valid_off", 32'(bus.rxtx_addr_valid), 32'h0);
      check("rd_start_off",      32'(bus.start_tx),        32'h0);
      send_word(32'h1C00_0200);
      check("rdwait_no_pulse", 32'(bus.start_tx),  32'h0);
      check("rdwait_addr",     bus.rxtx_addr,      32'h1C00_0100);
      end_frame();

      // WRITE_MEM with plug ready; second push coincides with pop
      bus.rx_ready = 1'b1;
      start_frame();
      send_cmd(8'h02);
      send_word(32'h1C00_0000);
      check("wr_addr_valid", 32'(bus.rxtx_addr_valid), 32'h1);
      check("wr_start",      32'(bus.start_tx),        32'h0);
      check("wr_addr",       bus.rxtx_addr,            32'h1C00_0000);
      send_word(32'hDEAD_BEEF);
      check("wr_d0_valid", 32'(bus.rx_valid), 32'h1);
      check("wr_d0",       bus.rx_data,       32'hDEAD_BEEF);
      send_word(32'h1234_5678);
      check("wr_d1_valid", 32'(bus.rx_valid), 32'h1);
      check("wr_d1",       bus.rx_data,       32'h1234_5678);
      tick();
      check("wr_drained", 32'(bus.rx_valid), 32'h0);
      check("wr_status",  32'(status),       32'h0);
      end_frame();

      // Overflow with plug stalled, then drain after cs rises
      bus.rx_ready = 1'b0;
      start_frame();
      send_cmd(8'h02);
      send_word(32'h1C00_0000);
      send_word(32'hDEAD_BEEF);
      send_word(32'hCAFE_F00D);
      send_word(32'h0BAD_F00D);
      check("ovf_data",   bus.rx_data,       32'hDEAD_BEEF);
      check("ovf_valid",  32'(bus.rx_valid), 32'h1);
      check("ovf_status", 32'(status),       32'h1);
      bus.cs = 1'b1;
      tick();
      check("ovf_hold_after_cs", 32'(bus.rx_valid), 32'h1);
      bus.rx_ready = 1'b1;
      n = 0;
      for (int i = 0; i < 4; i++) begin
         if (bus.rx_valid && bus.rx_ready) begin
            n++;
            check("ovf_deliver_data", bus.rx_data, 32'hDEAD_BEEF);
         end
         tick();
      end
      check("ovf_deliver_count", 32'(n),            32'd1);
      check("ovf_valid_after",   32'(bus.rx_valid), 32'h0);

      // SET_WRAP, unknown opcode, CLR_STATUS
      start_frame();
      send_cmd(8'h11);
      send_word(32'hABCD_0040);
      check("wrap_len", 32'(bus.wrap_length), 32'h0040);
      end_frame();
      start_frame();
      send_cmd(8'h55);
      check("bad_cmd_status", 32'(status), 32'h3);
      end_frame();
      start_frame();
      send_cmd(8'h07);
      check("clr_status", 32'(status), 32'h0);
      end_frame();

      // cmd and word together in CMD: word discarded
      start_frame();
      bus.cmd        = 8'h0B;
      bus.cmd_valid  = 1'b1;
      bus.word       = 32'h1C00_0010;
      bus.word_valid = 1'b1;
      tick();
      bus.cmd_valid  = 1'b0;
      bus.word_valid = 1'b0;
      check("cmdword_no_pulse", 32'(bus.rxtx_addr_valid), 32'h0);
      send_word(32'h1C00_0020);
      check("cmdword_addr",  bus.rxtx_addr,     32'h1C00_0020);
      check("cmdword_start", 32'(bus.start_tx), 32'h1);
      end_frame();

      // Frame aborted in ADDR, then a clean READ_MEM
      start_frame();
      send_cmd(8'h0B);
      bus.cs = 1'b1;
      tick();
      send_word(32'h1C00_0004);
      check("abort_addr_valid", 32'(bus.rxtx_addr_valid), 32'h0);
      check("abort_start",      32'(bus.start_tx),        32'h0);
      check("abort_addr",       bus.rxtx_addr,            32'h1C00_0020);
      tick();
      start_frame();
      send_cmd(8'h0B);
      send_word(32'h1C00_0008);
      check("rd2_addr",  bus.rxtx_addr,     32'h1C00_0008);
      check("rd2_start", 32'(bus.start_tx), 32'h1);
      end_frame();

      // Address outside the window: rejected only when the filter is built in
      start_frame();
      send_cmd(8'h0B);
      send_word(32'h2000_0000);
      check("oow_start",    32'(bus.start_tx),        32'(!FILT));
      check("oow_valid",    32'(bus.rxtx_addr_valid), 32'(!FILT));
      check("oow_addr_err", 32'(status[2]),           32'(FILT));
      end_frame();
      start_frame();
      send_cmd(8'h0B);
      send_word(32'h1C07_FFFC);
      check("top_win_start", 32'(bus.start_tx), 32'h1);
      check("top_win_addr",  bus.rxtx_addr,     32'h1C07_FFFC);
      end_frame();

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
